// File: rtl/change_dispenser.sv
// change_dispenser: releases latched quarter/dime/nickel counts as timed one-hot
// solenoid pulses (quarters first, then dimes, then nickels), keeps a running cents
// total for the current sequence and pulses done when the last coin has gone out.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start                   dispense request, only honoured in IDLE
//   quarter, dime, nickel   coin counts (0..15), latched on an accepted start
//   busy                    high while a coin sequence is running
//   done                    one-cycle completion pulse
//   coin_q, coin_d, coin_n  solenoid drives, at most one high at a time
//   paid_cents              cents released so far in the current sequence
module change_dispenser #(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GAP_CYC   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] quarter,
    input  logic [3:0] dime,
    input  logic [3:0] nickel,
    output logic       busy,
    output logic       done,
    output logic       coin_q,
    output logic       coin_d,
    output logic       coin_n,
    output logic [9:0] paid_cents
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    // Counter holds "cycles left minus one" in the current PULSE or GAP.
    localparam logic [7:0] PulseLoad = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GapLoad   = 8'(GAP_CYC - 1);

    state_e     r_state, w_state_d;
    logic [7:0] r_cnt, w_cnt_d;
    logic [3:0] r_rem_q, r_rem_d, r_rem_n;
    logic [3:0] w_rem_q_d, w_rem_d_d, w_rem_n_d;
    logic       r_busy, w_busy_d;
    logic       r_done, w_done_d;
    logic [2:0] r_coin, w_coin_d;  // {quarter, dime, nickel}
    logic [9:0] r_paid, w_paid_d;

    // Coin selection source: live inputs on an accepted start, latched counts after.
    logic [3:0] w_src_q, w_src_d, w_src_n;
    logic       w_pick_q, w_pick_d, w_pick_n, w_any;
    logic [9:0] w_cents;

    always_comb begin
        w_src_q  = (r_state == StIdle) ? quarter : r_rem_q;
        w_src_d  = (r_state == StIdle) ? dime    : r_rem_d;
        w_src_n  = (r_state == StIdle) ? nickel  : r_rem_n;
        w_pick_q = (w_src_q != 4'd0);
        w_pick_d = !w_pick_q && (w_src_d != 4'd0);
        w_pick_n = !w_pick_q && !w_pick_d && (w_src_n != 4'd0);
        w_any    = w_pick_q || w_pick_d || w_pick_n;
        w_cents  = w_pick_q ? 10'd25 : w_pick_d ? 10'd10 : w_pick_n ? 10'd5 : 10'd0;
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rem_q_d = r_rem_q;
        w_rem_d_d = r_rem_d;
        w_rem_n_d = r_rem_n;
        w_busy_d  = r_busy;
        w_done_d  = 1'b0;
        w_coin_d  = r_coin;
        w_paid_d  = r_paid;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_paid_d = w_cents;  // cleared, plus the first coin if any
                    if (w_any) begin
                        w_state_d = StPulse;
                        w_cnt_d   = PulseLoad;
                        w_busy_d  = 1'b1;
                        w_coin_d  = {w_pick_q, w_pick_d, w_pick_n};
                        w_rem_q_d = w_src_q - {3'b000, w_pick_q};
                        w_rem_d_d = w_src_d - {3'b000, w_pick_d};
                        w_rem_n_d = w_src_n - {3'b000, w_pick_n};
                    end else begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_rem_q_d = quarter;
                        w_rem_d_d = dime;
                        w_rem_n_d = nickel;
                    end
                end
            end
            StPulse: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StGap;
                    w_cnt_d   = GapLoad;
                    w_coin_d  = 3'b000;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StGap: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_d = r_cnt - 8'd1;
                end else if (w_any) begin
                    w_state_d = StPulse;
                    w_cnt_d   = PulseLoad;
                    w_coin_d  = {w_pick_q, w_pick_d, w_pick_n};
                    w_rem_q_d = w_src_q - {3'b000, w_pick_q};
                    w_rem_d_d = w_src_d - {3'b000, w_pick_d};
                    w_rem_n_d = w_src_n - {3'b000, w_pick_n};
                    w_paid_d  = r_paid + w_cents;
                end else begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_rem_q <= 4'd0;
            r_rem_d <= 4'd0;
            r_rem_n <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_coin  <= 3'b000;
            r_paid  <= 10'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rem_q <= w_rem_q_d;
            r_rem_d <= w_rem_d_d;
            r_rem_n <= w_rem_n_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_coin  <= w_coin_d;
            r_paid  <= w_paid_d;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign coin_q     = r_coin[2];
    assign coin_d     = r_coin[1];
    assign coin_n     = r_coin[0];
    assign paid_cents = r_paid;

endmodule
